fir_sample_ring: RTL and testbench
==================================

# fir_sample_ring

Input-sample delay line for the 64-tap FP16 FIR: synchronizes the slow-domain sample strobe into `clk_fast`, writes each FP16 sample into a 64-entry circular buffer, and on request streams the 64 most recent samples newest-to-oldest to the FIR constant-multiply phase. It sits directly upstream of the FIR datapath. The FIR control issues `rd_start` at the start of its multiply phase and consumes one sample per tap.

## Interface
- `DW`, 16, sample width (FP16)
- `DEPTH`, 64, taps / buffer entries (power of two)
- `clk_fast` in 1: fast clock
- `rst_n` in 1: reset, asynchronous, active-low
- `din` in DW: FP16 sample from the slow domain; stable from `valid_in` rise until 3 `clk_fast` edges later
- `valid_in` in 1: slow-domain sample strobe; asynchronous to `clk_fast`; held high ≥3 `clk_fast` cycles and low ≥3 cycles between samples
- `rd_start` in 1: pulse; begin a 64-beat stream
- `rd_ready` in 1: consumer accepts current beat
- `rd_data` out DW: sample for tap `rd_tap`
- `rd_valid` out 1: `rd_data`/`rd_tap`/`rd_last` valid
- `rd_tap` out 6: tap index, 0 = newest sample
- `rd_last` out 1: beat with tap 63
- `new_sample` out 1: one-cycle pulse when a sample is committed to the buffer
- `overrun` out 1: sticky; a sample was dropped

## Operation
- Strobe path: `valid_in` passes through a 2-flop synchronizer plus a third flop. A rising edge is detected when s2=1 and s3=0, and `din` is captured that cycle.
- States: IDLE, STREAM.
  - IDLE: a detected sample is written at `wr_ptr`. `wr_ptr` increments mod 64, `fill` increments and saturates at 64, and `new_sample` pulses.
  - STREAM: a detected sample goes to a one-entry hold register (`hold_full`=1).
- Drain: the hold register is written to RAM on the first cycle after STREAM exits, with `new_sample` pulsing then.
- Overrun: if a sample is detected while `hold_full`=1, the new sample is dropped and `overrun` is set. `overrun` clears only on reset.
- IDLE→STREAM: on `rd_start`. The stream base is `wr_ptr`−1 (mod 64), sampled the cycle after `rd_start`, so a write committed in the `rd_start` cycle is included as tap 0.
- STREAM beat k reads address base−k mod 64. Wrap is modular: base 2 reads 2,1,0,63,62…
- Unfilled taps (k ≥ `fill`) return 16'h0000, not RAM contents.
- A beat is transferred when `rd_valid` & `rd_ready`. While `rd_valid` & !`rd_ready`, `rd_data`, `rd_tap` and `rd_last` hold stable.
- STREAM→IDLE: on the transfer of the `rd_last` beat.
- `rd_start` in STREAM is ignored.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `rd_tap`=0, `rd_last`=0, `new_sample`=0, `overrun`=0. Internally `wr_ptr`=0, `fill`=0, hold empty, state IDLE. RAM contents are not cleared; the `fill` masking covers them.
- Sample commit: the 3rd `clk_fast` rising edge at which `valid_in` is sampled high, when IDLE.
- Stream latency: `rd_start` sampled at edge t gives the first `rd_valid` after edge t+2 (tap 0).
- Throughput: one beat per cycle with `rd_ready`=1, so 64 beats occupy cycles t+2..t+65.
- Reset assertion mid-stream aborts immediately, with all outputs at reset values.

## Configuration
- `FIR_SAMPLE_RING_DENORM_FLUSH_EN` defined: FP16 subnormal inputs (exp=0, mant≠0) are written as signed zero (sign preserved, all other bits 0).
- Undefined: samples are stored bit-exact.

## Structure
- Shared package `fir_pkg`:
  - `FP16_W`=16
  - `FIR_TAPS`=64
  - `fir_addr_t` (6-bit)
  - state enum {IDLE, STREAM}
  - FP16 field constants (sign bit 15, exp [14:10], mant [9:0])
- Sub-module `fir_ring_mem`: 64×16 RAM with one synchronous write port and one synchronous read port, 1-cycle read latency, read enable used for backpressure. All control (sync, pointers, fill, hold, FSM) stays in the top.

## Test plan
- Reset, write 3 samples (3C00, 4000, 4200), then `rd_start` with `rd_ready`=1 → taps 0..2 = 4200, 4000, 3C00; taps 3..63 = 0000; `rd_last` on tap 63; `rd_valid` first at t+2.
- Write 70 samples of value i (i=0..69) → stream tap k = 69−k for k=0..63, covering pointer wrap.
- Sample arrives mid-stream → not visible in the current stream; `new_sample` pulses the cycle after the `rd_last` transfer; the next stream's tap 0 = that sample.
- Two samples arrive during one stream → the first is committed after the stream, the second is dropped, and `overrun`=1 stays set.
- Toggle `rd_ready` 1,0,0,1 during stream → `rd_data`/`rd_tap` are held while `rd_ready`=0; no beats are lost or duplicated; 64 transfers total.
- Write 0x8001 → reads 0x8000 with `FIR_SAMPLE_RING_DENORM_FLUSH_EN` defined, 0x8001 without; `rst_n` low at beat 10 → `rd_valid`=0 immediately and the next stream returns all zeros.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR definitions: FP16 field layout, tap count, address type, stream states
// and the subnormal-flush helper used when FIR_SAMPLE_RING_DENORM_FLUSH_EN is defined.
package fir_pkg;

    localparam int FP16_W        = 16;
    localparam int FIR_TAPS      = 64;
    localparam int FIR_AW        = 6;

    localparam int FP16_SIGN_BIT = 15;
    localparam int FP16_EXP_MSB  = 14;
    localparam int FP16_EXP_LSB  = 10;
    localparam int FP16_MANT_MSB = 9;
    localparam int FP16_MANT_LSB = 0;

    typedef logic [FIR_AW-1:0] fir_addr_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } fir_state_e;

    // Subnormal (exp == 0, mant != 0) becomes a zero that keeps its sign.
    function automatic logic [FP16_W-1:0] fp16_flush_denorm(input logic [FP16_W-1:0] x);
        logic [FP16_W-1:0] r;
        r = x;
        if ((x[FP16_EXP_MSB:FP16_EXP_LSB] == 5'd0) &&
            (x[FP16_MANT_MSB:FP16_MANT_LSB] != 10'd0)) begin
            r                = {FP16_W{1'b0}};
            r[FP16_SIGN_BIT] = x[FP16_SIGN_BIT];
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_ring_mem.sv
// Sample storage for the FIR delay line: one synchronous write port and one
// synchronous read port whose output register only updates while re is high.
module fir_ring_mem
    import fir_pkg::*;
#(
    parameter int DW    = FP16_W,
    parameter int DEPTH = FIR_TAPS
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Storage array and read register; contents are never cleared, the reader masks unfilled taps.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fir_sample_ring.sv
// 64-entry FP16 sample ring feeding the FIR multiply phase newest-to-oldest.
// Build option FIR_SAMPLE_RING_DENORM_FLUSH_EN stores subnormal inputs as signed zero.
module fir_sample_ring
    import fir_pkg::*;
#(
    parameter int DW    = FP16_W,
    parameter int DEPTH = FIR_TAPS
) (
    input  logic                     clk_fast,
    input  logic                     rst_n,
    input  logic [DW-1:0]            din,
    input  logic                     valid_in,
    input  logic                     rd_start,
    input  logic                     rd_ready,
    output logic [DW-1:0]            rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH)-1:0] rd_tap,
    output logic                     rd_last,
    output logic                     new_sample,
    output logic                     overrun
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_TAP = AW'(DEPTH - 1);

    logic          sync1_q, sync2_q, sync3_q;
    logic          detect_s;
    logic [DW-1:0] din_s;
    fir_state_e    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          overrun_q, overrun_d;
    logic          new_sample_q, new_sample_d;
    logic [AW:0]   issue_q, issue_d;
    logic          s1_valid_q, s1_valid_d;
    logic [AW-1:0] s1_tap_q, s1_tap_d;
    logic          s1_zero_q, s1_zero_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic [AW-1:0] rd_tap_q, rd_tap_d;
    logic          rd_last_q, rd_last_d;
    logic          we_s, re_s, advance_s, last_xfer_s;
    logic [DW-1:0] wdata_s, mem_rdata_s;
    logic [AW-1:0] raddr_s;

`ifdef FIR_SAMPLE_RING_DENORM_FLUSH_EN
    assign din_s = fp16_flush_denorm(din);
`else
    assign din_s = din;
`endif

    assign detect_s    = sync2_q & ~sync3_q;
    assign advance_s   = ~rd_valid_q | rd_ready;
    assign last_xfer_s = rd_valid_q & rd_ready & rd_last_q;

    // Strobe synchronizer plus edge-detect stage.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= valid_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Write/hold bookkeeping, stream FSM and the two-stage read pipeline.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        overrun_d    = overrun_q;
        new_sample_d = 1'b0;
        issue_d      = issue_q;
        s1_valid_d   = s1_valid_q;
        s1_tap_d     = s1_tap_q;
        s1_zero_d    = s1_zero_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = rd_valid_q;
        rd_tap_d     = rd_tap_q;
        rd_last_d    = rd_last_q;
        we_s         = 1'b0;
        wdata_s      = din_s;
        re_s         = 1'b0;
        // Pointer is frozen during STREAM, so wr_ptr-1 is the stream base throughout.
        raddr_s      = wr_ptr_q - AW'(1) - issue_q[AW-1:0];

        case (state_q)
            IDLE: begin
                issue_d      = {(AW+1){1'b0}};
                new_sample_d = detect_s;
                if (hold_full_q) begin
                    we_s    = 1'b1;
                    wdata_s = hold_q;
                    if (detect_s) begin
                        hold_d = din_s;
                    end else begin
                        hold_full_d = 1'b0;
                    end
                end else if (detect_s) begin
                    we_s    = 1'b1;
                    wdata_s = din_s;
                end else begin
                    we_s = 1'b0;
                end
                if (rd_start) begin
                    state_d = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                new_sample_d = last_xfer_s & hold_full_q;
                if (detect_s && hold_full_q) begin
                    overrun_d = 1'b1;
                end else if (detect_s) begin
                    hold_d      = din_s;
                    hold_full_d = 1'b1;
                end else begin
                    hold_full_d = hold_full_q;
                end
                if (advance_s) begin
                    rd_valid_d = s1_valid_q;
                    rd_tap_d   = s1_tap_q;
                    rd_last_d  = s1_valid_q && (s1_tap_q == LAST_TAP);
                    rd_data_d  = (s1_valid_q && !s1_zero_q) ? mem_rdata_s : {DW{1'b0}};
                    if (issue_q < FILL_MAX) begin
                        re_s       = 1'b1;
                        s1_valid_d = 1'b1;
                        s1_tap_d   = issue_q[AW-1:0];
                        s1_zero_d  = (issue_q >= fill_q);
                        issue_d    = issue_q + (AW+1)'(1);
                    end else begin
                        s1_valid_d = 1'b0;
                    end
                end else begin
                    re_s = 1'b0;
                end
                if (last_xfer_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = STREAM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (we_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + (AW+1)'(1);
            end else begin
                fill_d = fill_q;
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= {AW{1'b0}};
            fill_q       <= {(AW+1){1'b0}};
            hold_q       <= {DW{1'b0}};
            hold_full_q  <= 1'b0;
            overrun_q    <= 1'b0;
            new_sample_q <= 1'b0;
            issue_q      <= {(AW+1){1'b0}};
            s1_valid_q   <= 1'b0;
            s1_tap_q     <= {AW{1'b0}};
            s1_zero_q    <= 1'b0;
            rd_data_q    <= {DW{1'b0}};
            rd_valid_q   <= 1'b0;
            rd_tap_q     <= {AW{1'b0}};
            rd_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            overrun_q    <= overrun_d;
            new_sample_q <= new_sample_d;
            issue_q      <= issue_d;
            s1_valid_q   <= s1_valid_d;
            s1_tap_q     <= s1_tap_d;
            s1_zero_q    <= s1_zero_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            rd_tap_q     <= rd_tap_d;
            rd_last_q    <= rd_last_d;
        end
    end

    fir_ring_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk_fast),
        .we    (we_s),
        .waddr (wr_ptr_q),
        .wdata (wdata_s),
        .re    (re_s),
        .raddr (raddr_s),
        .rdata (mem_rdata_s)
    );

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign rd_tap     = rd_tap_q;
    assign rd_last    = rd_last_q;
    assign new_sample = new_sample_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_fir_sample_ring.sv
// Self-checking bench for fir_sample_ring: table vectors, hand-written corner sequences,
// and random sample/backpressure traffic against a queue-based history model.
module tb_fir_sample_ring;

    logic        clk_fast = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic        valid_in;
    logic        rd_start;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [5:0]  rd_tap;
    logic        rd_last;
    logic        new_sample;
    logic        overrun;

    int n_chk  = 0;
    int n_pass = 0;
    int ns_cnt = 0;
    int model_commits = 0;
    logic [15:0] hist[$];
    logic [15:0] exp_tap[64];

    typedef struct {
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[7];

    fir_sample_ring dut (
        .clk_fast   (clk_fast),
        .rst_n      (rst_n),
        .din        (din),
        .valid_in   (valid_in),
        .rd_start   (rd_start),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_tap     (rd_tap),
        .rd_last    (rd_last),
        .new_sample (new_sample),
        .overrun    (overrun)
    );

    always #5 clk_fast = ~clk_fast;

    always @(negedge clk_fast) begin
        if (rst_n && new_sample) ns_cnt++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    // What the ring is expected to hold for an input sample.
    function automatic logic [15:0] stored(input logic [15:0] v);
`ifdef FIR_SAMPLE_RING_DENORM_FLUSH_EN
        if ((((v >> 10) & 16'h001F) == 16'h0000) && ((v & 16'h03FF) != 16'h0000))
            return v & 16'h8000;
`endif
        return v;
    endfunction

    task automatic build_expected();
        for (int k = 0; k < 64; k++)
            exp_tap[k] = (k < hist.size()) ? hist[hist.size() - 1 - k] : 16'h0000;
    endtask

    task automatic send_sample(input logic [15:0] v);
        @(negedge clk_fast);
        din      = v;
        valid_in = 1'b1;
        repeat (4) @(negedge clk_fast);
        valid_in = 1'b0;
        repeat (4) @(negedge clk_fast);
    endtask

    task automatic push_idle(input logic [15:0] v);
        send_sample(v);
        hist.push_back(stored(v));
        model_commits++;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic run_stream(input int mode, input int abort_at, input bit chk_ns);
        int ntr, lat, vcnt;
        bit pstall;
        logic [15:0] pd;
        logic [5:0]  pt;
        logic        pl;
        build_expected();
        ntr = 0; lat = -1; vcnt = 0; pstall = 1'b0;
        pd = 16'h0; pt = 6'h0; pl = 1'b0;
        @(negedge clk_fast);
        rd_start = 1'b1;
        rd_ready = 1'b1;
        @(negedge clk_fast);
        rd_start = 1'b0;
        for (int cyc = 0; cyc < 400 && ntr < 64; cyc++) begin
            if (cyc > 0) @(negedge clk_fast);
            if (rd_valid && lat < 0) lat = cyc;
            if (abort_at >= 0 && ntr == abort_at && rd_valid) begin
                rst_n = 1'b0;
                #1;
                check("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
                check("abort_rd_data", {16'd0, rd_data}, 32'd0);
                check("abort_rd_tap", {26'd0, rd_tap}, 32'd0);
                return;
            end
            if (rd_valid) begin
                if (pstall) begin
                    check("stall_data", {16'd0, rd_data}, {16'd0, pd});
                    check("stall_tap", {26'd0, rd_tap}, {26'd0, pt});
                    check("stall_last", {31'd0, rd_last}, {31'd0, pl});
                end
                case (mode)
                    0: rd_ready = 1'b1;
                    1: rd_ready = (vcnt % 4 == 0) || (vcnt % 4 == 3);
                    default: rd_ready = 1'($urandom_range(0, 1));
                endcase
                vcnt++;
                if (rd_ready) begin
                    check("tap_idx", {26'd0, rd_tap}, ntr);
                    check("tap_data", {16'd0, rd_data}, {16'd0, exp_tap[ntr]});
                    check("tap_last", {31'd0, rd_last}, {31'd0, (ntr == 63)});
                    ntr++;
                end
                pstall = !rd_ready;
                pd = rd_data; pt = rd_tap; pl = rd_last;
            end
        end
        check("stream_latency", lat, 2);
        check("stream_beats", ntr, 64);
        @(negedge clk_fast);
        rd_ready = 1'b1;
        check("stream_end_valid", {31'd0, rd_valid}, 32'd0);
        if (chk_ns) check("drain_new_sample", {31'd0, new_sample}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; din = 16'h0; valid_in = 1'b0; rd_start = 1'b0; rd_ready = 1'b1;
        repeat (3) @(negedge clk_fast);
        check("rst_rd_data", {16'd0, rd_data}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_tap", {26'd0, rd_tap}, 32'd0);
        check("rst_rd_last", {31'd0, rd_last}, 32'd0);
        check("rst_new_sample", {31'd0, new_sample}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk_fast);

        // Commit timing: pulse appears after the 3rd edge that sees valid_in high.
        din = 16'h3C00; valid_in = 1'b1;
        @(negedge clk_fast);
        @(negedge clk_fast);
        check("commit_e2", {31'd0, new_sample}, 32'd0);
        @(negedge clk_fast);
        check("commit_e3", {31'd0, new_sample}, 32'd1);
        @(negedge clk_fast);
        check("commit_e4", {31'd0, new_sample}, 32'd0);
        valid_in = 1'b0;
        repeat (4) @(negedge clk_fast);
        hist.push_back(16'h3C00); model_commits++;
        push_idle(16'h4000);
        push_idle(16'h4200);
        run_stream(0, -1, 1'b0);

        // Pointer wrap: 70 samples of value i.
        for (int i = 0; i < 70; i++) push_idle(16'(i));
        run_stream(0, -1, 1'b0);
        run_stream(1, -1, 1'b0);

        // One sample during a stream: deferred, then newest tap of the next stream.
        fork
            run_stream(1, -1, 1'b1);
            begin
                repeat (10) @(negedge clk_fast);
                send_sample(16'h5555);
            end
        join
        hist.push_back(stored(16'h5555)); model_commits++;
        check("no_overrun", {31'd0, overrun}, 32'd0);
        run_stream(0, -1, 1'b0);

        // Two samples during a stream: second dropped, overrun sticky.
        fork
            run_stream(2, -1, 1'b1);
            begin
                repeat (10) @(negedge clk_fast);
                send_sample(16'h6666);
                send_sample(16'h7777);
            end
        join
        hist.push_back(stored(16'h6666)); model_commits++;
        check("overrun_set", {31'd0, overrun}, 32'd1);
        run_stream(0, -1, 1'b0);
        check("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Table of FP16 encodings including subnormals.
        vecs[0] = '{16'h3C00, 16'h3C00};
        vecs[1] = '{16'h0400, 16'h0400};
        vecs[2] = '{16'h7C00, 16'h7C00};
        vecs[3] = '{16'hFC01, 16'hFC01};
`ifdef FIR_SAMPLE_RING_DENORM_FLUSH_EN
        vecs[4] = '{16'h8001, 16'h8000};
        vecs[5] = '{16'h0001, 16'h0000};
        vecs[6] = '{16'h83FF, 16'h8000};
`else
        vecs[4] = '{16'h8001, 16'h8001};
        vecs[5] = '{16'h0001, 16'h0001};
        vecs[6] = '{16'h83FF, 16'h83FF};
`endif
        for (int i = 0; i < 7; i++) begin
            send_sample(vecs[i].din);
            hist.push_back(vecs[i].exp); model_commits++;
            run_stream(0, -1, 1'b0);
        end

        // Random samples with random backpressure.
        for (int r = 0; r < 3; r++) begin
            int n;
            n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) push_idle(16'($urandom));
            run_stream(2, -1, 1'b0);
        end
        check("new_sample_count", ns_cnt, model_commits);

        // Reset during beat 10 aborts; the next stream sees an empty ring.
        run_stream(0, 10, 1'b0);
        hist.delete();
        repeat (3) @(negedge clk_fast);
        rst_n = 1'b1;
        check("post_rst_overrun", {31'd0, overrun}, 32'd0);
        run_stream(2, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
